// File: rtl/vga_vram_scheduler_pkg.sv
// Shared video timing constants for the 800x600 display path.
// Used by the VRAM scheduler and the timing generator.
package vga_vram_scheduler_pkg;

  localparam int H_ACTIVE = 800;
  localparam int H_FP     = 40;
  localparam int H_SYNC   = 128;
  localparam int H_BP     = 88;
  localparam int H_TOTAL  = 1056;

  localparam int V_ACTIVE = 600;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 4;
  localparam int V_BP     = 23;
  localparam int V_TOTAL  = 628;

  function automatic logic [15:0] next_line(
    input logic [15:0] v
  );
    return (v == 16'(V_TOTAL - 1)) ? 16'd0 : v + 16'd1;
  endfunction

endpackage

// File: rtl/vga_vram_scheduler_line_buffer.sv
// Ping-pong scanline buffer: two banks of one line each,
// one synchronous write port and one 1-cycle read port.
module vga_line_buffer #(
  parameter int DATA_W = 8,
  parameter int WORDS  = 200,
  parameter int WORD_W = 8
) (
  input  logic              i_pix_clk,
  input  logic              i_we,
  input  logic              i_wbank,
  input  logic [WORD_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_rbank,
  input  logic [WORD_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2][WORDS];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_pix_clk) begin
    if (i_we) begin
      r_mem[i_wbank][i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_rbank][i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/vga_vram_scheduler.sv
// Single-port VRAM arbiter: per-line display prefetch into a
// ping-pong buffer, host writes in idle slots, pixel streaming.
module vga_vram_scheduler
  import vga_vram_scheduler_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 15,
  parameter int SCALE_LOG2 = 2
) (
  input  logic              i_pix_clk,
  input  logic              i_reset,
  input  logic [15:0]       i_horz_coord,
  input  logic [15:0]       i_vert_coord,
  input  logic              i_in_active_area,
  output logic [ADDR_W-1:0] o_vram_addr,
  output logic              o_vram_re,
  output logic              o_vram_we,
  output logic [DATA_W-1:0] o_vram_wdata,
  input  logic [DATA_W-1:0] i_vram_rdata,
  input  logic              i_host_req,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_wdata,
  output logic              o_host_ack,
  output logic [DATA_W-1:0] o_pixel,
  output logic              o_pixel_valid
);

  localparam int LINE_WORDS = H_ACTIVE >> SCALE_LOG2;
  localparam int WORD_W     = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [15:0]       w_next_line;
  logic              w_trigger;
  logic [ADDR_W-1:0] w_base;
  logic              w_last;
  logic              w_vram_re;
  logic              w_grant;

  logic [WORD_W-1:0] r_word;
  logic [ADDR_W-1:0] r_base;
  logic              r_bank;
  logic              r_cap_valid;
  logic [WORD_W-1:0] r_cap_word;

  logic              r_host_we;
  logic [ADDR_W-1:0] r_host_addr;
  logic [DATA_W-1:0] r_host_wdata;

  logic              r_active_d1;
  logic [DATA_W-1:0] w_lb_rdata;
  logic [WORD_W-1:0] w_rd_word;
  logic [DATA_W-1:0] r_pixel;
  logic              r_pixel_valid;

  assign w_next_line = next_line(i_vert_coord);
  assign w_trigger   = (i_horz_coord == 16'd0) &&
                       (w_next_line < 16'(V_ACTIVE));
  assign w_base      = ADDR_W'(w_next_line >> SCALE_LOG2) *
                       ADDR_W'(LINE_WORDS);
  assign w_last      = (r_word == WORD_W'(LINE_WORDS - 1));

  always_ff @(posedge i_pix_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_trigger) w_next = S_FETCH;
      S_FETCH: if (w_last) w_next = S_DRAIN;
      S_DRAIN: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Host only gets a slot when the display is not fetching,
  // and never in the cycle its previous write is on the bus.
  always_comb begin
    w_vram_re = (r_state == S_FETCH);
    w_grant   = (r_state == S_IDLE) && !w_trigger &&
                i_host_req && !r_host_we;
    if (r_host_we) begin
      o_vram_addr = r_host_addr;
    end else if (w_vram_re) begin
      o_vram_addr = r_base + ADDR_W'(r_word);
    end else begin
      o_vram_addr = '0;
    end
    o_vram_wdata = r_host_we ? r_host_wdata : '0;
  end

  assign o_vram_re  = w_vram_re;
  assign o_vram_we  = r_host_we;
  assign o_host_ack = r_host_we;

  always_ff @(posedge i_pix_clk) begin
    if (i_reset) begin
      r_word       <= '0;
      r_base       <= '0;
      r_bank       <= 1'b0;
      r_cap_valid  <= 1'b0;
      r_cap_word   <= '0;
      r_host_we    <= 1'b0;
      r_host_addr  <= '0;
      r_host_wdata <= '0;
    end else begin
      r_cap_valid <= w_vram_re;
      r_cap_word  <= r_word;
      if (r_state == S_IDLE && w_trigger) begin
        r_base <= w_base;
        r_bank <= w_next_line[0];
        r_word <= '0;
      end else if (r_state == S_FETCH) begin
        r_word <= r_word + 1'b1;
      end
      r_host_we <= w_grant;
      if (w_grant) begin
        r_host_addr  <= i_host_addr;
        r_host_wdata <= i_host_wdata;
      end
    end
  end

  assign w_rd_word = WORD_W'(i_horz_coord >> SCALE_LOG2);

  vga_line_buffer #(
    .DATA_W (DATA_W),
    .WORDS  (LINE_WORDS),
    .WORD_W (WORD_W)
  ) u_line_buffer (
    .i_pix_clk (i_pix_clk),
    .i_we      (r_cap_valid),
    .i_wbank   (r_bank),
    .i_waddr   (r_cap_word),
    .i_wdata   (i_vram_rdata),
    .i_rbank   (i_vert_coord[0]),
    .i_raddr   (w_rd_word),
    .o_rdata   (w_lb_rdata)
  );

  always_ff @(posedge i_pix_clk) begin
    if (i_reset) begin
      r_active_d1   <= 1'b0;
      r_pixel       <= '0;
      r_pixel_valid <= 1'b0;
    end else begin
      r_active_d1   <= i_in_active_area;
      r_pixel_valid <= r_active_d1;
      r_pixel       <= r_active_d1 ? w_lb_rdata : '0;
    end
  end

  assign o_pixel       = r_pixel;
  assign o_pixel_valid = r_pixel_valid;

endmodule
